// File: rtl/spram_uart_dump.sv
// ============================================================================
// Module   : spram_uart_dump
// Brief    : Reads 16-bit SPRAM words and paces them out as UART bytes, hi first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spram_uart_dump #(
  parameter int BIT_WIDTH     = 11,
  parameter int BAUD_RATE     = 4000000,
  parameter int CLOCK_FREQ_HZ = 40000000,
  parameter int RD_LAT        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] word_count,
  output logic [15:0] ram_addr,
  input  logic [15:0] ram_data,
  output logic        ram_own,
  output logic        send,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done
);

  localparam int C_BYTE_CYCLES = BIT_WIDTH * CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int C_CW          = $clog2(C_BYTE_CYCLES + 1);

  // A counter loaded with N-1 expires exactly N edges after the load.
  localparam logic [C_CW-1:0] C_RD_LOAD  = C_CW'(RD_LAT - 1);
  localparam logic [C_CW-1:0] C_GAP_LOAD = C_CW'(C_BYTE_CYCLES - 1);
  localparam logic [C_CW-1:0] C_PRE_LOAD = C_CW'(C_BYTE_CYCLES - RD_LAT - 1);

  generate
    if (C_BYTE_CYCLES <= RD_LAT + 1 || RD_LAT < 1) begin : g_param_check
      $error("spram_uart_dump: BYTE_CYCLES must exceed RD_LAT+1 and RD_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_GAP_HI  = 3'd2,
    S_GAP_LO  = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t          r_state, w_state;
  logic [C_CW-1:0] r_cnt,   w_cnt;
  logic [15:0]     r_rem,   w_rem;
  logic [15:0]     r_addr,  w_addr;
  logic [15:0]     r_word,  w_word;
  logic [7:0]      r_tx,    w_tx;
  logic            r_send,  w_send;
  logic            r_busy,  w_busy;
  logic            r_own,   w_own;
  logic            r_done,  w_done;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_rem   = r_rem;
    w_addr  = r_addr;
    w_word  = r_word;
    w_tx    = r_tx;
    w_send  = 1'b0;
    w_busy  = r_busy;
    w_own   = r_own;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rem = word_count;
          if (word_count == 16'd0) begin
            w_state = S_FIN;
          end else begin
            w_addr  = base_addr;
            w_busy  = 1'b1;
            w_own   = 1'b1;
            w_cnt   = C_RD_LOAD;
            w_state = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_word  = ram_data;
          w_tx    = ram_data[15:8];
          w_send  = 1'b1;
          w_cnt   = C_GAP_LOAD;
          w_state = S_GAP_HI;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      S_GAP_HI: begin
        if (r_cnt == '0) begin
          w_tx    = r_word[7:0];
          w_send  = 1'b1;
          // Words after this one need the address early so the read lands on time.
          w_cnt   = (r_rem > 16'd1) ? C_PRE_LOAD : C_GAP_LOAD;
          w_state = S_GAP_LO;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      S_GAP_LO: begin
        if (r_cnt == '0) begin
          if (r_rem > 16'd1) begin
            w_addr  = r_addr + 16'd1;
            w_rem   = r_rem - 16'd1;
            w_cnt   = C_RD_LOAD;
            w_state = S_RD_WAIT;
          end else begin
            w_rem   = 16'd0;
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_own   = 1'b0;
            w_state = S_IDLE;
          end
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      S_FIN: begin
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_addr  <= '0;
      r_word  <= '0;
      r_tx    <= '0;
      r_send  <= 1'b0;
      r_busy  <= 1'b0;
      r_own   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_rem   <= w_rem;
      r_addr  <= w_addr;
      r_word  <= w_word;
      r_tx    <= w_tx;
      r_send  <= w_send;
      r_busy  <= w_busy;
      r_own   <= w_own;
      r_done  <= w_done;
    end
  end

  assign ram_addr = r_addr;
  assign ram_own  = r_own;
  assign send     = r_send;
  assign tx_data  = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spram_uart_dump.sv
// ============================================================================
// Module   : tb_spram_uart_dump
// Brief    : Scoreboard bench: driver queues expected bytes/done, monitor checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spram_uart_dump;

  localparam int C_BC = 110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [15:0] ram_addr;
  logic [15:0] ram_data = '0;
  logic        ram_own;
  logic        send;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;

  spram_uart_dump dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_own    (ram_own),
    .send       (send),
    .tx_data    (tx_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // One register stage gives data valid two edges after the address edge.
  logic [15:0] mem [0:65535];
  always @(posedge clk) ram_data <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int b;
    int t;
    int addr;
  } exp_t;

  exp_t q_bytes[$];
  int   q_done[$];
  int   checks = 0;
  int   errors = 0;
  int   n_sends = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (send) begin
      n_sends++;
      if (q_bytes.size() == 0) fail("unexpected_send");
      else begin
        e = q_bytes.pop_front();
        chk("tx_data", int'(tx_data), e.b);
        chk("send_cycle", cyc, e.t);
        if (e.addr >= 0) chk("ram_addr", int'(ram_addr), e.addr);
      end
    end
    if (done) begin
      if (q_done.size() == 0) fail("unexpected_done");
      else begin
        chk("done_cycle", cyc, q_done.pop_front());
        chk("busy_at_done", int'(busy), 0);
        chk("ram_own_at_done", int'(ram_own), 0);
      end
    end
  end

  task automatic start_run(input logic [15:0] base, input int n, input logic [15:0] w [4]);
    int t0;
    logic [15:0] a;
    @(posedge clk); #1;
    t0 = cyc + 1;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      mem[a] = w[i];
      q_bytes.push_back('{int'(w[i][15:8]), t0 + 2 + 2 * i * C_BC, int'(a)});
      q_bytes.push_back('{int'(w[i][7:0]), t0 + 2 + (2 * i + 1) * C_BC, -1});
    end
    q_done.push_back((n == 0) ? t0 + 1 : t0 + 2 + 2 * n * C_BC);
    start = 1'b1; base_addr = base; word_count = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int left;
    left = budget;
    while ((q_bytes.size() != 0 || q_done.size() != 0) && left > 0) begin
      @(posedge clk); #1;
      left--;
    end
    if (left == 0) begin
      fail("timeout_waiting_for_transfer");
      q_bytes.delete();
      q_done.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_send"}, int'(send), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ram_own"}, int'(ram_own), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int target;
    int left;
    // Reset with start held high
    start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk_quiet("reset");
    end
    rst = 1'b0; start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk_quiet("post_reset");
    end

    // Four-word dump
    start_run(16'h0000, 4, '{16'h0001, 16'h0002, 16'h0004, 16'h0007});
    @(posedge clk); #1;
    chk("busy_during", int'(busy), 1);
    chk("ram_own_during", int'(ram_own), 1);
    wait_idle(2000);

    // Start mid-transfer is ignored
    start_run(16'h0000, 4, '{16'h0001, 16'h0002, 16'h0004, 16'h0007});
    repeat (300) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 16'h0002; word_count = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(2000);

    // Zero-length dump
    start_run(16'h0010, 0, '{16'h0, 16'h0, 16'h0, 16'h0});
    chk("count0_busy", int'(busy), 0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("count0_busy", int'(busy), 0);
    end
    wait_idle(50);

    // Address wrap
    start_run(16'hFFFF, 2, '{16'hABCD, 16'h1234, 16'h0, 16'h0});
    wait_idle(1000);

    // Reset after the third send
    target = n_sends + 3;
    start_run(16'h0000, 4, '{16'h1234, 16'h0002, 16'h0004, 16'h0007});
    left = 1000;
    while (n_sends < target && left > 0) begin
      @(posedge clk); #1;
      left--;
    end
    if (left == 0) fail("timeout_third_send");
    @(posedge clk); #1;
    rst = 1'b1;
    q_bytes.delete();
    q_done.delete();
    @(posedge clk); #1;
    chk_quiet("abort");
    rst = 1'b0;
    repeat (250) @(posedge clk);
    #1;
    start_run(16'h0002, 1, '{16'h0004, 16'h0, 16'h0, 16'h0});
    wait_idle(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
